// File: rtl/dmglcd_capture.sv
// rtl/dmglcd_capture.sv - DMG LCD receive-side capture: rebuilds pixel stream with x/y from async LCD strobes.
// Define DMGLCD_CAPTURE_POL_CHECK_EN to add the sticky pol_err output.
module dmglcd_capture #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 144
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] lcd_d,
  input  logic       lcd_clk,
  input  logic       lcd_hsync,
  input  logic       lcd_vsync,
  input  logic       lcd_latch,
  input  logic       lcd_pol,
  output logic       pix_valid,
  output logic [7:0] pix_x,
  output logic [7:0] pix_y,
  output logic [1:0] pix_data,
  output logic       frame_start,
  output logic       frame_done,
  output logic       line_err,
  output logic       synced
`ifdef DMGLCD_CAPTURE_POL_CHECK_EN
  ,
  output logic       pol_err
`endif
);

  localparam logic [7:0] W8   = 8'(WIDTH);
  localparam logic [7:0] H8   = 8'(HEIGHT);
  localparam logic [7:0] HMAX = 8'(HEIGHT - 1);

  typedef enum logic [1:0] {WAIT_VSYNC, LINE_IDLE, HS_HIGH, PIXELS} state_t;

  state_t     state, state_n;
  logic [5:0] s1, s2;
  logic [3:0] prev;
  logic [7:0] x, x_n, y, y_n, emit_x;
  logic       emit, fs_n, fd_n, err_set;
  logic       vs_rise, latch_rise, hs_rise, hs_fall, clk_fall;
  logic [1:0] d_s2;

  // Data rides the same two-stage path as the strobes so it stays aligned with them.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
    end else begin
      s1   <= {lcd_latch, lcd_vsync, lcd_hsync, lcd_clk, lcd_d};
      s2   <= s1;
      prev <= s2[5:2];
    end
  end

  assign d_s2       = s2[1:0];
  assign clk_fall   = ~s2[2] &  prev[0];
  assign hs_rise    =  s2[3] & ~prev[1];
  assign hs_fall    = ~s2[3] &  prev[1];
  assign vs_rise    =  s2[4] & ~prev[2];
  assign latch_rise =  s2[5] & ~prev[3];

  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    emit    = 1'b0;
    emit_x  = x;
    fs_n    = 1'b0;
    fd_n    = 1'b0;
    err_set = 1'b0;
    if (vs_rise) begin
      state_n = LINE_IDLE;
      x_n     = 8'd0;
      y_n     = 8'd0;
      fs_n    = 1'b1;
    end else if (state != WAIT_VSYNC) begin
      if (latch_rise) begin
        state_n = LINE_IDLE;
        if (state == PIXELS) begin
          x_n = 8'd0;
          if (x != W8) err_set = 1'b1;
          if (y == HMAX) begin
            y_n  = 8'd0;
            fd_n = 1'b1;
          end else begin
            y_n = y + 8'd1;
          end
        end
      end else if (hs_rise) begin
        state_n = HS_HIGH;
        x_n     = 8'd0;
        if (state == PIXELS || y >= H8) err_set = 1'b1;
      end else if (hs_fall) begin
        if (state == HS_HIGH) begin
          emit    = 1'b1;
          emit_x  = 8'd0;
          x_n     = 8'd1;
          state_n = PIXELS;
        end
      end else if (clk_fall && state == PIXELS) begin
        // Extra clocks past the line width are dropped and flagged.
        if (x < W8) begin
          emit = 1'b1;
          x_n  = x + 8'd1;
        end else begin
          err_set = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_VSYNC;
      x           <= 8'd0;
      y           <= 8'd0;
      pix_valid   <= 1'b0;
      pix_x       <= 8'd0;
      pix_y       <= 8'd0;
      pix_data    <= 2'd0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
      synced      <= 1'b0;
    end else begin
      state       <= state_n;
      x           <= x_n;
      y           <= y_n;
      pix_valid   <= emit;
      frame_start <= fs_n;
      frame_done  <= fd_n;
      line_err    <= line_err | err_set;
      synced      <= synced | fs_n;
      if (emit) begin
        pix_x    <= emit_x;
        pix_y    <= y;
        pix_data <= d_s2;
      end
    end
  end

`ifdef DMGLCD_CAPTURE_POL_CHECK_EN
  logic pol_s1, pol_s2, pol_last, pol_seen;

  // Polarity only matters at latch rises, so extra toggles inside a line are harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      pol_s1   <= 1'b0;
      pol_s2   <= 1'b0;
      pol_last <= 1'b0;
      pol_seen <= 1'b0;
      pol_err  <= 1'b0;
    end else begin
      pol_s1 <= lcd_pol;
      pol_s2 <= pol_s1;
      if (vs_rise) begin
        pol_seen <= 1'b0;
      end else if (latch_rise && state != WAIT_VSYNC) begin
        if (pol_seen && pol_s2 == pol_last) pol_err <= 1'b1;
        pol_last <= pol_s2;
        pol_seen <= 1'b1;
      end
    end
  end
`else
  logic unused_pol;
  assign unused_pol = lcd_pol;
`endif

endmodule

// File: tb/tb_dmglcd_capture.sv
// tb/tb_dmglcd_capture.sv - scoreboard bench for dmglcd_capture: directed LCD driver, queued pixel expectations.
module tb_dmglcd_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] lcd_d = 2'd0;
  logic       lcd_clk = 1'b0;
  logic       lcd_hsync = 1'b0;
  logic       lcd_vsync = 1'b0;
  logic       lcd_latch = 1'b0;
  logic       lcd_pol = 1'b0;
  logic       pix_valid;
  logic [7:0] pix_x, pix_y;
  logic [1:0] pix_data;
  logic       frame_start, frame_done, line_err, synced;
`ifdef DMGLCD_CAPTURE_POL_CHECK_EN
  logic       pol_err;
`endif

  int checks = 0;
  int errors = 0;
  int fd_count = 0;
  int pix_count = 0;
  logic [17:0] exp_q[$];

  dmglcd_capture dut (
    .clk(clk), .reset(reset), .lcd_d(lcd_d), .lcd_clk(lcd_clk), .lcd_hsync(lcd_hsync),
    .lcd_vsync(lcd_vsync), .lcd_latch(lcd_latch), .lcd_pol(lcd_pol), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .frame_start(frame_start),
    .frame_done(frame_done), .line_err(line_err), .synced(synced)
`ifdef DMGLCD_CAPTURE_POL_CHECK_EN
    , .pol_err(pol_err)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: every strobe must match the head of the expectation queue.
  always @(negedge clk) begin
    if (frame_done) fd_count++;
    if (pix_valid) begin
      pix_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d d=%0d, none expected", pix_x, pix_y, pix_data);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        if ({pix_x, pix_y, pix_data} !== e) begin
          errors++;
          $display("FAIL pixel: got x=%0d y=%0d d=%0d expected x=%0d y=%0d d=%0d",
                   pix_x, pix_y, pix_data, e[17:10], e[9:2], e[1:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] pixval(input int px, input int py, input int pat);
    if (pat == 0) return 2'((px + py) & 3);
    return 2'((px * 3 + py + 1) & 3);
  endfunction

  // One line: hsync pulse with optional dummy clocks, npix pixels (first on hsync fall), latch pulse.
  task automatic send_line(input int npix, input int ndummy, input int lw, input int yy,
                           input bit expect_px, input bit pol_tog, input int pat);
    lcd_hsync = 1'b1;
    wait_cyc(lw);
    for (int i = 0; i < ndummy; i++) begin
      lcd_clk = 1'b1; wait_cyc(lw);
      lcd_clk = 1'b0; wait_cyc(lw);
    end
    for (int i = 0; i < npix; i++) begin
      lcd_d = pixval(i, yy, pat);
      if (expect_px && i < 160) exp_q.push_back({8'(i), 8'(yy), lcd_d});
      if (i == 0) begin
        lcd_hsync = 1'b0;
        wait_cyc(lw);
      end else begin
        lcd_clk = 1'b1; wait_cyc(lw);
        lcd_clk = 1'b0; wait_cyc(lw);
      end
    end
    if (pol_tog) lcd_pol = ~lcd_pol;
    lcd_latch = 1'b1; wait_cyc(lw);
    lcd_latch = 1'b0; wait_cyc(lw + 1);
  endtask

  task automatic vsync_pulse();
    lcd_vsync = 1'b1; wait_cyc(2);
    lcd_vsync = 1'b0; wait_cyc(2);
  endtask

  initial begin
    int fd0, pc0;
    // Reset state
    wait_cyc(3);
    @(negedge clk);
    check("reset_pix_valid", pix_valid, 0);
    check("reset_frame_start", frame_start, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_line_err", line_err, 0);
    check("reset_synced", synced, 0);
    check("reset_pix_xy", {pix_x, pix_y, pix_data}, 0);
    reset = 1'b0;
    wait_cyc(1);

    // Activity before any vsync produces nothing
    send_line(20, 2, 2, 0, 1'b0, 1'b1, 1);
    wait_cyc(5);
    check("presync_synced", synced, 0);
    check("presync_line_err", line_err, 0);

    // vsync rise -> frame_start exactly 3 clk later
    lcd_vsync = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("vsync_fs_early", frame_start, 0);
    @(negedge clk);
    check("vsync_fs_3clk", frame_start, 1);
    @(negedge clk);
    check("vsync_fs_pulse", frame_start, 0);
    check("vsync_synced", synced, 1);
    lcd_vsync = 1'b0;
    wait_cyc(3);

    // Full line with dummy clocks during hsync, then short line, then normal line
    send_line(160, 3, 2, 0, 1'b1, 1'b1, 1);
    wait_cyc(5);
    check("full_line_err", line_err, 0);
    send_line(150, 0, 2, 1, 1'b1, 1'b1, 1);
    wait_cyc(5);
    check("short_line_err", line_err, 1);
    send_line(160, 0, 2, 2, 1'b1, 1'b1, 1);
    wait_cyc(5);
    check("short_queue_empty", exp_q.size(), 0);

    // Reset mid-line, then vsync and one clean line
    lcd_hsync = 1'b1; wait_cyc(2);
    for (int i = 0; i < 40; i++) begin
      lcd_d = pixval(i, 3, 1);
      exp_q.push_back({8'(i), 8'd3, lcd_d});
      if (i == 0) begin
        lcd_hsync = 1'b0; wait_cyc(2);
      end else begin
        lcd_clk = 1'b1; wait_cyc(2);
        lcd_clk = 1'b0; wait_cyc(2);
      end
    end
    wait_cyc(6);
    reset = 1'b1;
    lcd_clk = 1'b1; wait_cyc(2);
    lcd_clk = 1'b0; wait_cyc(2);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      lcd_clk = 1'b1; wait_cyc(2);
      lcd_clk = 1'b0; wait_cyc(2);
    end
    lcd_latch = 1'b1; wait_cyc(2);
    lcd_latch = 1'b0; wait_cyc(4);
    check("midreset_synced", synced, 0);
    check("midreset_line_err", line_err, 0);
    vsync_pulse();
    send_line(160, 0, 2, 0, 1'b1, 1'b1, 0);
    wait_cyc(5);
    check("midreset_new_line_err", line_err, 0);
    check("midreset_queue_empty", exp_q.size(), 0);

    // Full frame, ramp pattern, fast pixel clock
    fd0 = fd_count;
    pc0 = pix_count;
    vsync_pulse();
    for (int yy = 0; yy < 144; yy++) begin
      send_line(160, 1, 1, yy, 1'b1, 1'b1, 0);
      wait_cyc(1);
    end
    wait_cyc(6);
    check("frame_done_count", fd_count - fd0, 1);
    check("frame_pixel_count", pix_count - pc0, 23040);
    check("frame_line_err", line_err, 0);
    check("frame_queue_empty", exp_q.size(), 0);
    check("frame_synced", synced, 1);

`ifdef DMGLCD_CAPTURE_POL_CHECK_EN
    check("pol_toggle_ok", pol_err, 0);
    send_line(160, 0, 2, 0, 1'b1, 1'b0, 0);
    wait_cyc(5);
    check("pol_constant_err", pol_err, 1);
`endif

    // After wrap, y restarts at 0 without a new vsync
    send_line(160, 0, 2, 0, 1'b1, 1'b1, 1);
`ifdef DMGLCD_CAPTURE_POL_CHECK_EN
    exp_q.delete();
`endif
    wait_cyc(5);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_line_err", line_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
